// File: rtl/dmem_responder_if.sv
// Core-side data bus plus the TX drain port of the data-memory responder.
// Handshake: a TX word transfers at a rising edge where tx_valid && tx_ready; tx_data holds while tx_valid && !tx_ready.
interface dmem_responder_if;
   logic [31:0] addr;
   logic [31:0] wd_dm;
   logic        we_dm;
   logic [31:0] rd_dm;
   logic        irq;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output addr, wd_dm, we_dm, tx_ready,
      input  rd_dm, irq, tx_data, tx_valid
   );

   modport slave (
      input  addr, wd_dm, we_dm, tx_ready,
      output rd_dm, irq, tx_data, tx_valid
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, free-running counter with compare flag,
// and a TX FIFO drained by a downstream peripheral.
module dmem_responder #(
   parameter int RAM_AW  = 8,
   parameter int FIFO_AW = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic [31:0]        ram      [2**RAM_AW];
   logic [31:0]        fifo_mem [DEPTH];
   logic [31:0]        cnt, cmp;
   logic               match_flag, ovf;
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;

   logic               hi_zero, ram_sel, per_sel;
   logic [1:0]         reg_sel;
   logic [RAM_AW-1:0]  ram_idx;
   logic               wr_ram, wr_cnt, wr_cmp, wr_stat, push;
   logic               full, empty, pop, push_ok;
   logic [31:0]        stat_word;
   logic               unused_addr_bits;

   assign hi_zero = (bus.addr[31:12] == 20'd0);
   assign ram_sel = hi_zero && (bus.addr[11:10] == 2'b00);
   assign per_sel = hi_zero && (bus.addr[11:10] == 2'b10);
   assign reg_sel = bus.addr[3:2];
   // Bits between the RAM index and bit 9 alias onto the same words.
   assign ram_idx = bus.addr[RAM_AW+1:2];
   assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[9:4]};

   assign wr_ram  = bus.we_dm && ram_sel;
   assign wr_cnt  = bus.we_dm && per_sel && (reg_sel == 2'd0);
   assign wr_cmp  = bus.we_dm && per_sel && (reg_sel == 2'd1);
   assign wr_stat = bus.we_dm && per_sel && (reg_sel == 2'd2);
   assign push    = bus.we_dm && per_sel && (reg_sel == 2'd3);

   assign full    = (count == (FIFO_AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop     = !empty && bus.tx_ready;
   // A pop in the same edge frees the slot, so a push to a full FIFO still lands.
   assign push_ok = push && (!full || pop);

   assign stat_word = {16'b0, 3'b0, 5'(count), 4'b0, ovf, empty, full, match_flag};

   assign bus.irq      = match_flag;
   assign bus.tx_valid = !empty;
   assign bus.tx_data  = fifo_mem[rd_ptr];

   always_comb begin
      bus.rd_dm = 32'd0;
      if (ram_sel) begin
         bus.rd_dm = ram[ram_idx];
      end else if (per_sel) begin
         case (reg_sel)
            2'd0:    bus.rd_dm = cnt;
            2'd1:    bus.rd_dm = cmp;
            2'd2:    bus.rd_dm = stat_word;
            default: bus.rd_dm = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ram) ram[ram_idx] <= bus.wd_dm;
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.wd_dm;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 32'd0;
         cmp        <= 32'hFFFF_FFFF;
         match_flag <= 1'b0;
         ovf        <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         cnt <= wr_cnt ? bus.wd_dm : cnt + 32'd1;
         if (wr_cmp) cmp <= bus.wd_dm;

         // Hardware set takes priority over a software clear in the same edge.
         if (cnt == cmp)                 match_flag <= 1'b1;
         else if (wr_stat && bus.wd_dm[0]) match_flag <= 1'b0;

         if (push && full && !pop)       ovf <= 1'b1;
         else if (wr_stat && bus.wd_dm[3]) ovf <= 1'b0;

         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM decode, counter, compare flag, TX FIFO and async reset.
module tb_dmem_responder;
   localparam logic [31:0] A_CNT  = 32'h0000_0800;
   localparam logic [31:0] A_CMP  = 32'h0000_0804;
   localparam logic [31:0] A_STAT = 32'h0000_0808;
   localparam logic [31:0] A_TXD  = 32'h0000_080C;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   dmem_responder_if bus();

   dmem_responder #(.RAM_AW(8), .FIFO_AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Driver tasks: the bench always rests at 1 time unit after a rising edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wd_dm = d;
      bus.we_dm = 1'b1;
      @(posedge clk);
      #1;
      bus.we_dm = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.addr  = a;
      bus.we_dm = 1'b0;
      #1;
      d = bus.rd_dm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      tick();
      bus_read(A_CNT, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp %h", v, 32'd0); end
      bus_read(A_CMP, v);
      checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got %h exp %h", v, 32'hFFFF_FFFF); end
      bus_read(A_STAT, v);
      checks++; if (v !== 32'h0000_0004) begin errors++; $display("FAIL reset_stat got %h exp %h", v, 32'h4); end
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
   endtask

   task automatic test_counter();
      logic [31:0] v;
      logic [31:0] exp_seq [4];
      exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus_read(A_CNT, v);
      checks++; if (v !== 32'd5) begin errors++; $display("FAIL cnt_after_5 got %h exp %h", v, 32'd5); end
      bus_write(A_CNT, 32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         bus_read(A_CNT, v);
         checks++; if (v !== exp_seq[i]) begin errors++; $display("FAIL cnt_wrap[%0d] got %h exp %h", i, v, exp_seq[i]); end
         tick();
      end
   endtask

   task automatic test_ram();
      logic [31:0] v;
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0010, v);
      checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rw got %h exp %h", v, 32'hDEAD_BEEF); end
      bus_read(32'h0000_0400, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL unmapped_400 got %h exp 0", v); end
      bus_read(32'h0000_1800, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL unmapped_1800 got %h exp 0", v); end
      bus_read(A_TXD, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL txd_read got %h exp 0", v); end
      bus_write(32'h0000_0000, 32'hA5A5_A5A5);
      bus_write(32'h0000_1000, 32'h1234_5678);
      bus_write(32'h0000_0C10, 32'h8765_4321);
      bus_read(32'h0000_0000, v);
      checks++; if (v !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ram_w0_after_unmapped got %h exp %h", v, 32'hA5A5_A5A5); end
      bus_read(32'h0000_0010, v);
      checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_w4_after_unmapped got %h exp %h", v, 32'hDEAD_BEEF); end
   endtask

   task automatic test_match();
      logic [31:0] v;
      bit found;
      bus_write(A_CMP, 32'd20);
      bus_write(A_CNT, 32'd0);
      bus_write(A_STAT, 32'h1);
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL match_cleared got %b exp 0", bus.irq); end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus_read(A_CNT, v);
         if (v == 32'd20) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL match_reach_20 got %b exp 1", found); end
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_during_eq got %b exp 0", bus.irq); end
      tick();
      checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_after_eq got %b exp 1", bus.irq); end
      bus_write(A_CNT, 32'd18);
      tick();
      tick();
      bus_read(A_CNT, v);
      checks++; if (v !== 32'd20) begin errors++; $display("FAIL cnt_at_cmp got %h exp %h", v, 32'd20); end
      bus_write(A_STAT, 32'h1);
      checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL set_wins_clear got %b exp 1", bus.irq); end
      bus_write(A_STAT, 32'h1);
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL plain_clear got %b exp 0", bus.irq); end
   endtask

   task automatic test_fifo();
      logic [31:0] v;
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) bus_write(A_TXD, 32'(i));
      bus_read(A_STAT, v);
      checks++; if ((v & 32'hFFFF_FFFE) !== 32'h0000_0402) begin errors++; $display("FAIL fifo_full_stat got %h exp %h", v & 32'hFFFF_FFFE, 32'h402); end
      bus_write(A_TXD, 32'd5);
      bus_read(A_STAT, v);
      checks++; if ((v & 32'hFFFF_FFFE) !== 32'h0000_040A) begin errors++; $display("FAIL fifo_ovf_stat got %h exp %h", v & 32'hFFFF_FFFE, 32'h40A); end
      checks++; if (bus.tx_data !== 32'd1 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL fifo_head_held got %h/%b exp 1/1", bus.tx_data, bus.tx_valid); end
      bus.tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'(i)) begin errors++; $display("FAIL fifo_drain[%0d] got %h/%b exp %h/1", i, bus.tx_data, bus.tx_valid, 32'(i)); end
         tick();
      end
      bus.tx_ready = 1'b0;
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained_valid got %b exp 0", bus.tx_valid); end
      bus_read(A_STAT, v);
      checks++; if ((v & 32'hFFFF_FFFE) !== 32'h0000_000C) begin errors++; $display("FAIL fifo_empty_stat got %h exp %h", v & 32'hFFFF_FFFE, 32'hC); end
      bus_write(A_STAT, 32'h8);
      bus_read(A_STAT, v);
      checks++; if ((v & 32'hFFFF_FFFE) !== 32'h0000_0004) begin errors++; $display("FAIL ovf_clear got %h exp %h", v & 32'hFFFF_FFFE, 32'h4); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [31:0] exp_q [$];
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) bus_write(A_TXD, 32'(i));
      bus.addr     = A_TXD;
      bus.wd_dm    = 32'd9;
      bus.we_dm    = 1'b1;
      bus.tx_ready = 1'b1;
      tick();
      bus.we_dm    = 1'b0;
      bus.tx_ready = 1'b0;
      bus_read(A_STAT, v);
      checks++; if ((v & 32'hFFFF_FFFE) !== 32'h0000_0402) begin errors++; $display("FAIL b2b_stat got %h exp %h", v & 32'hFFFF_FFFE, 32'h402); end
      exp_q = '{32'd2, 32'd3, 32'd4, 32'd9};
      bus.tx_ready = 1'b1;
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== v) begin errors++; $display("FAIL b2b_drain got %h/%b exp %h/1", bus.tx_data, bus.tx_valid, v); end
         tick();
      end
      bus.tx_ready = 1'b0;
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", bus.tx_valid); end
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      bus.tx_ready = 1'b0;
      bus_write(A_CMP, 32'd50);
      bus_write(A_CNT, 32'd49);
      tick();
      tick();
      for (int i = 1; i <= 3; i++) bus_write(A_TXD, 32'(i + 16));
      bus_read(A_STAT, v);
      checks++; if (((v >> 8) & 32'h1F) !== 32'd3 || bus.irq !== 1'b1) begin errors++; $display("FAIL pre_reset got count %0d irq %b exp 3/1", (v >> 8) & 32'h1F, bus.irq); end
      bus.addr = A_CNT;
      #1;
      rst = 1'b0;
      #1;
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL async_tx_valid got %b exp 0", bus.tx_valid); end
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b exp 0", bus.irq); end
      checks++; if (bus.rd_dm !== 32'd0) begin errors++; $display("FAIL async_cnt got %h exp 0", bus.rd_dm); end
      rst = 1'b1;
      tick();
      checks++; if (bus.tx_valid !== 1'b0 || bus.rd_dm !== 32'd1) begin errors++; $display("FAIL post_release got %b/%h exp 0/%h", bus.tx_valid, bus.rd_dm, 32'd1); end
   endtask

   initial begin
      bus.addr     = 32'd0;
      bus.wd_dm    = 32'd0;
      bus.we_dm    = 1'b0;
      bus.tx_ready = 1'b0;
      test_reset();
      test_counter();
      test_ram();
      test_match();
      test_fifo();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side bus responder at the far end of the core's data-memory interface.
- The core drives address, write data and write enable, and receives read data combinationally in the same cycle.
- Contains a word RAM, a free-running cycle counter with compare/interrupt flag, and a transmit FIFO that a downstream peripheral drains over a valid/ready handshake.
- Sits beside the instruction memory at SoC top level.

Parameters:
- RAM_AW, 8, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- FIFO_AW, 2, TX FIFO pointer width; depth is 2^FIFO_AW entries.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- addr, input, 32, byte address from the core (the core's alu_out); bits [1:0] ignored.
- wd_dm, input, 32, write data.
- we_dm, input, 1, write enable; a write is performed at the rising edge when high.
- rd_dm, output, 32, combinational read data for addr.
- irq, output, 1, equals match_flag.
- tx_data, output, 32, FIFO head word.
- tx_valid, output, 1, FIFO non-empty.
- tx_ready, input, 1, downstream accepts the head word.

Behaviour:
- Decode, when addr[31:12] != 0: unmapped.
  - addr[11:10]=00: RAM, word index addr[RAM_AW+1:2]; addr bits above that, up to bit 9, are ignored (aliasing).
  - addr[11:10]=10: peripheral register, selected by addr[3:2]; addr[9:4] ignored.
  - addr[11:10]=01 or 11: unmapped.
- Unmapped accesses: read returns 0; writes are ignored.
- Peripheral registers:
  - 00 CNT: R = counter. W = load counter with wd_dm.
  - 01 CMP: R/W compare value.
  - 10 STAT: R = {16'b0, 3'b0, count[4:0] zero-extended from FIFO_AW+1 bits, 4'b0, ovf, empty, full, match_flag}. W: wd_dm[0]=1 clears match_flag; wd_dm[3]=1 clears ovf; other bits ignored.
  - 11 TXD: W = push wd_dm into FIFO. R = 0.
- Reads: purely combinational from current state; zero cycles of latency. A write is not visible on rd_dm until the cycle after its edge.
- RAM: write at edge when we_dm and RAM selected; read asynchronous. Contents are not reset.
- Counter:
  - Increments by 1 every cycle; wraps 0xFFFF_FFFF to 0.
  - A CNT write in the same cycle overrides the increment (counter = wd_dm next cycle).
- Match:
  - At each edge where the current counter == CMP, match_flag sets.
  - Simultaneous set and software clear: set wins.
  - A CMP write takes effect for the comparison from the following cycle.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (FIFO_AW+1 bits).
  - full = (count == depth); empty = (count == 0).
  - tx_valid = !empty; tx_data = mem[rd_ptr].
  - Pop occurs at an edge when tx_valid && tx_ready.
  - Push occurs at an edge on a TXD write.
  - Push when full with no simultaneous pop: word dropped, ovf sets (sticky until cleared by STAT write); ovf set wins over a same-cycle clear.
  - Push and pop in the same cycle (including when full): both occur, count unchanged.
  - Push while empty: tx_valid rises in the next cycle (no fall-through).
  - Pointers wrap modulo depth.
  - tx_data is held stable while tx_valid && !tx_ready.
- Reset (rst low, async):
  - Counter=0, CMP=0xFFFF_FFFF, match_flag=0, ovf=0.
  - FIFO pointers and count=0, so tx_valid=0 and irq=0.
  - rd_dm reflects the reset state; RAM is unchanged.
  - Reset mid-operation discards FIFO contents immediately.
  - Release is synchronous to no particular edge; the first update occurs at the first rising edge with rst high.

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 the next cycle -> rd_dm=0xDEADBEEF. Read 0x0000_0400 -> 0; write to 0x0000_1000 leaves RAM unchanged.
- Counter: release reset, read CNT after 5 edges -> 5. Write CNT=0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0, 1 on successive cycles.
- Match: CMP=20, CNT=0 -> irq rises on the cycle after the counter reads 20. Write STAT bit0=1 in the same cycle the counter again equals CMP -> irq stays 1.
- FIFO fill/overflow with FIFO_AW=2 and tx_ready=0: push 1,2,3,4 -> STAT full=1, count=4. Push 5 -> ovf=1, count=4. Raise tx_ready -> tx_data sequence 1,2,3,4, then tx_valid=0, empty=1.
- Simultaneous push/pop: FIFO full, tx_ready=1 and TXD write 9 in the same cycle -> count stays 4; 9 emerges after 2,3,4.
- Async reset: assert rst low mid-stream with FIFO count=3 and irq=1 -> tx_valid=0, irq=0 and CNT read=0 without a clock edge.
